// File: rtl/hazard_sequencer_if.sv
// ---------------------------------------------------------------------------
// hazard_sequencer_if
// Groups the hazard/stall sequencer's pipeline-facing signals.
//   master : the core side (drives the cache/hazard status, reads the
//            load/bubble/flush controls and the performance counters)
//   slave  : the sequencer itself
// Status in  : imem_req, imem_resp, dmem_req, dmem_resp, id_sr1, id_sr2,
//              id_sr1_used, id_sr2_used, ex_memread, ex_destreg,
//              mem_ctrl_taken
// Control out: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
//              bubble_id_ex, flush_if_id, flush_ex_mem, pc_sel_target,
//              stall_count, flush_count
// ---------------------------------------------------------------------------
interface hazard_sequencer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 imem_req;
    logic                 imem_resp;
    logic                 dmem_req;
    logic                 dmem_resp;
    logic [2:0]           id_sr1;
    logic [2:0]           id_sr2;
    logic                 id_sr1_used;
    logic                 id_sr2_used;
    logic                 ex_memread;
    logic [2:0]           ex_destreg;
    logic                 mem_ctrl_taken;

    logic                 load_pc;
    logic                 load_if_id;
    logic                 load_id_ex;
    logic                 load_ex_mem;
    logic                 load_mem_wb;
    logic                 bubble_id_ex;
    logic                 flush_if_id;
    logic                 flush_ex_mem;
    logic                 pc_sel_target;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        output imem_req, imem_resp, dmem_req, dmem_resp,
               id_sr1, id_sr2, id_sr1_used, id_sr2_used,
               ex_memread, ex_destreg, mem_ctrl_taken,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               bubble_id_ex, flush_if_id, flush_ex_mem, pc_sel_target,
               stall_count, flush_count
    );

    modport slave (
        input  imem_req, imem_resp, dmem_req, dmem_resp,
               id_sr1, id_sr2, id_sr1_used, id_sr2_used,
               ex_memread, ex_destreg, mem_ctrl_taken,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               bubble_id_ex, flush_if_id, flush_ex_mem, pc_sel_target,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_sequencer.sv
// ---------------------------------------------------------------------------
// hazard_sequencer
// Stall/flush sequencer for the 5-stage LC-3b pipeline. Produces the load
// enables for PC and the four pipeline registers, inserts ID/EX bubbles on
// load-use hazards and I-cache misses, freezes the pipe on D-cache misses,
// and flushes younger stages when a taken control transfer resolves in MEM.
// Saturating counters track stalled cycles and committed control flushes.
// Ports:
//   clk : core clock, all state on rising edge
//   rst : synchronous, active-high reset
//   hz  : hazard_sequencer_if.slave (status in, controls/counters out)
// Control outputs are combinational from state and inputs; the counters
// are registered.
// ---------------------------------------------------------------------------
module hazard_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_sequencer_if.slave   hz
);

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_FLUSH_PEND = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic dstall_s;
    logic istall_s;
    logic lu_s;
    logic flush_inc_s;

    logic load_pc_s;
    logic load_if_id_s;
    logic load_id_ex_s;
    logic load_ex_mem_s;
    logic load_mem_wb_s;
    logic bubble_id_ex_s;
    logic flush_if_id_s;
    logic flush_ex_mem_s;
    logic pc_sel_target_s;

    assign dstall_s = hz.dmem_req & ~hz.dmem_resp;
    assign istall_s = hz.imem_req & ~hz.imem_resp;
    assign lu_s     = hz.ex_memread &
                      ((hz.id_sr1_used & (hz.ex_destreg == hz.id_sr1)) |
                       (hz.id_sr2_used & (hz.ex_destreg == hz.id_sr2)));

    // Next-state and pipeline control decode
    always_comb begin
        state_d         = state_q;
        flush_inc_s     = 1'b0;
        load_pc_s       = 1'b0;
        load_if_id_s    = 1'b0;
        load_id_ex_s    = 1'b0;
        load_ex_mem_s   = 1'b0;
        load_mem_wb_s   = 1'b0;
        bubble_id_ex_s  = 1'b0;
        flush_if_id_s   = 1'b0;
        flush_ex_mem_s  = 1'b0;
        pc_sel_target_s = 1'b0;

        if (rst) begin
            // Controls stay low; any pending flush is dropped.
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dstall_s) begin
                        // Full freeze; a taken branch in MEM is held until release.
                        state_d = ST_RUN;
                    end else if (hz.mem_ctrl_taken & ~istall_s) begin
                        // Redirect now; also covers a coincident load-use, whose
                        // ID instruction is on the wrong path anyway.
                        load_pc_s       = 1'b1;
                        load_if_id_s    = 1'b1;
                        load_id_ex_s    = 1'b1;
                        load_ex_mem_s   = 1'b1;
                        load_mem_wb_s   = 1'b1;
                        pc_sel_target_s = 1'b1;
                        flush_if_id_s   = 1'b1;
                        bubble_id_ex_s  = 1'b1;
                        flush_ex_mem_s  = 1'b1;
                        flush_inc_s     = 1'b1;
                    end else if (hz.mem_ctrl_taken) begin
                        // Fetch is stuck: kill the younger in-flight work now and
                        // redirect PC once the I-cache answers.
                        load_id_ex_s   = 1'b1;
                        load_ex_mem_s  = 1'b1;
                        load_mem_wb_s  = 1'b1;
                        bubble_id_ex_s = 1'b1;
                        flush_ex_mem_s = 1'b1;
                        state_d        = ST_FLUSH_PEND;
                    end else if (lu_s | istall_s) begin
                        // Hold PC and IF/ID, let older stages drain behind a bubble.
                        load_id_ex_s   = 1'b1;
                        load_ex_mem_s  = 1'b1;
                        load_mem_wb_s  = 1'b1;
                        bubble_id_ex_s = 1'b1;
                    end else begin
                        load_pc_s     = 1'b1;
                        load_if_id_s  = 1'b1;
                        load_id_ex_s  = 1'b1;
                        load_ex_mem_s = 1'b1;
                        load_mem_wb_s = 1'b1;
                    end
                end
                ST_FLUSH_PEND: begin
                    // MEM holds a bubble here, so mem_ctrl_taken is not consulted.
                    if (dstall_s) begin
                        state_d = ST_FLUSH_PEND;
                    end else if (istall_s) begin
                        load_id_ex_s   = 1'b1;
                        load_ex_mem_s  = 1'b1;
                        load_mem_wb_s  = 1'b1;
                        bubble_id_ex_s = 1'b1;
                    end else begin
                        // Fetch released: take the remembered target.
                        load_pc_s       = 1'b1;
                        load_if_id_s    = 1'b1;
                        load_id_ex_s    = 1'b1;
                        load_ex_mem_s   = 1'b1;
                        load_mem_wb_s   = 1'b1;
                        pc_sel_target_s = 1'b1;
                        flush_if_id_s   = 1'b1;
                        bubble_id_ex_s  = 1'b1;
                        flush_inc_s     = 1'b1;
                        state_d         = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Saturating counter next values
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (~load_pc_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_inc_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
            flush_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.load_pc       = load_pc_s;
    assign hz.load_if_id    = load_if_id_s;
    assign hz.load_id_ex    = load_id_ex_s;
    assign hz.load_ex_mem   = load_ex_mem_s;
    assign hz.load_mem_wb   = load_mem_wb_s;
    assign hz.bubble_id_ex  = bubble_id_ex_s;
    assign hz.flush_if_id   = flush_if_id_s;
    assign hz.flush_ex_mem  = flush_ex_mem_s;
    assign hz.pc_sel_target = pc_sel_target_s;
    assign hz.stall_count   = stall_cnt_q;
    assign hz.flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hazard_sequencer
// Directed vectors with hand-computed expectations for hazard_sequencer.
// Control outputs are compared as a 9-bit vector:
//   {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
//    bubble_id_ex, flush_if_id, flush_ex_mem, pc_sel_target}
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_hazard_sequencer;

    localparam int CW = 16;

    localparam logic [8:0] V_OFF    = 9'b00000_0000; // reset / D-miss freeze
    localparam logic [8:0] V_RUN    = 9'b11111_0000;
    localparam logic [8:0] V_STALL  = 9'b00111_1000; // load-use / I-miss
    localparam logic [8:0] V_BR     = 9'b11111_1111; // taken, fetch ready
    localparam logic [8:0] V_PEND   = 9'b00111_1010; // taken during I-miss
    localparam logic [8:0] V_DONE   = 9'b11111_1101; // pending redirect issued

    logic clk;
    logic rst;
    int   err_cnt;
    int   chk_cnt;

    hazard_sequencer_if #(.CNT_WIDTH(CW)) bus ();

    hazard_sequencer #(.CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    logic [8:0] outv;
    assign outv = {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
                   bus.load_mem_wb, bus.bubble_id_ex, bus.flush_if_id,
                   bus.flush_ex_mem, bus.pc_sel_target};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.imem_req       = 1'b0;
        bus.imem_resp      = 1'b0;
        bus.dmem_req       = 1'b0;
        bus.dmem_resp      = 1'b0;
        bus.id_sr1         = 3'd0;
        bus.id_sr2         = 3'd0;
        bus.id_sr1_used    = 1'b0;
        bus.id_sr2_used    = 1'b0;
        bus.ex_memread     = 1'b0;
        bus.ex_destreg     = 3'd7;
        bus.mem_ctrl_taken = 1'b0;
    endtask

    // Check controls for the current inputs, then advance past one rising edge.
    task automatic step_chk(input string tag, input logic [8:0] exp);
        #1;
        check_eq(tag, {23'd0, outv}, {23'd0, exp});
        @(negedge clk);
    endtask

    task automatic cnt_chk(input string tag, input int s, input int f);
        check_eq({tag, "_stall"}, {16'd0, bus.stall_count}, s);
        check_eq({tag, "_flush"}, {16'd0, bus.flush_count}, f);
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst = 1'b1;
        idle_in();
        @(negedge clk);

        // Reset for two edges: controls held low
        step_chk("rst_a", V_OFF);
        step_chk("rst_b", V_OFF);
        rst = 1'b0;
        cnt_chk("after_rst", 0, 0);
        step_chk("idle", V_RUN);

        // Load-use on sr1: one bubble, then normal flow
        bus.ex_memread = 1'b1; bus.ex_destreg = 3'd3; bus.id_sr1 = 3'd3; bus.id_sr1_used = 1'b1;
        step_chk("lu_sr1", V_STALL);
        idle_in();
        step_chk("lu_after", V_RUN);
        cnt_chk("lu", 1, 0);

        // Register mismatch and unused sr2 match: no hazard
        bus.ex_memread = 1'b1; bus.ex_destreg = 3'd3; bus.id_sr1 = 3'd4; bus.id_sr1_used = 1'b1;
        bus.id_sr2 = 3'd3; bus.id_sr2_used = 1'b0;
        step_chk("lu_nomatch", V_RUN);
        // sr2 match used
        bus.id_sr1_used = 1'b0; bus.id_sr2_used = 1'b1;
        step_chk("lu_sr2", V_STALL);
        // Not a load: forwarding covers it
        bus.ex_memread = 1'b0;
        step_chk("lu_noload", V_RUN);
        idle_in();
        cnt_chk("lu2", 2, 0);

        // D-miss for 4 cycles then response
        bus.dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) step_chk("dmiss", V_OFF);
        bus.dmem_resp = 1'b1;
        step_chk("dmiss_rel", V_RUN);
        idle_in();
        cnt_chk("dmiss", 6, 0);

        // Taken branch with fetch ready
        bus.mem_ctrl_taken = 1'b1;
        step_chk("br", V_BR);
        idle_in();
        cnt_chk("br", 6, 1);

        // Branch waits out a D-miss, handled the cycle the freeze releases
        bus.mem_ctrl_taken = 1'b1; bus.dmem_req = 1'b1;
        step_chk("br_dstall", V_OFF);
        bus.dmem_resp = 1'b1;
        step_chk("br_drel", V_BR);
        idle_in();
        cnt_chk("br_d", 7, 2);

        // Load-use together with a taken branch: branch wins
        bus.mem_ctrl_taken = 1'b1;
        bus.ex_memread = 1'b1; bus.ex_destreg = 3'd2; bus.id_sr1 = 3'd2; bus.id_sr1_used = 1'b1;
        step_chk("br_lu", V_BR);
        idle_in();
        cnt_chk("br_lu", 7, 3);

        // Branch during I-miss; response 3 cycles after the taken cycle
        bus.mem_ctrl_taken = 1'b1; bus.imem_req = 1'b1;
        step_chk("bri_enter", V_PEND);
        step_chk("bri_wait1", V_STALL);   // taken still high: ignored while pending
        bus.mem_ctrl_taken = 1'b0;
        step_chk("bri_wait2", V_STALL);
        bus.imem_resp = 1'b1;
        step_chk("bri_done", V_DONE);
        idle_in();
        step_chk("bri_idle", V_RUN);
        cnt_chk("bri", 10, 4);

        // D-miss while the redirect is pending still freezes everything
        bus.mem_ctrl_taken = 1'b1; bus.imem_req = 1'b1;
        step_chk("brd_enter", V_PEND);
        bus.mem_ctrl_taken = 1'b0; bus.dmem_req = 1'b1;
        step_chk("brd_frz", V_OFF);
        bus.imem_resp = 1'b1;
        step_chk("brd_frz2", V_OFF);
        bus.dmem_resp = 1'b1;
        step_chk("brd_done", V_DONE);
        idle_in();
        step_chk("brd_idle", V_RUN);
        cnt_chk("brd", 13, 5);

        // Reset while pending drops the redirect
        bus.mem_ctrl_taken = 1'b1; bus.imem_req = 1'b1;
        step_chk("rstp_enter", V_PEND);
        bus.mem_ctrl_taken = 1'b0;
        rst = 1'b1;
        step_chk("rstp_rst", V_OFF);
        rst = 1'b0;
        idle_in();
        step_chk("rstp_idle", V_RUN);
        cnt_chk("rstp", 0, 0);

        // Plain I-miss stall in RUN
        bus.imem_req = 1'b1;
        step_chk("imiss", V_STALL);
        idle_in();
        cnt_chk("imiss", 1, 0);

        // Stall counter saturation: 2^16+5 frozen cycles
        bus.dmem_req = 1'b1;
        repeat (65541) @(negedge clk);
        cnt_chk("sat", 65535, 0);
        step_chk("sat_frz", V_OFF);
        cnt_chk("sat_hold", 65535, 0);
        idle_in();
        step_chk("sat_idle", V_RUN);
        cnt_chk("sat_end", 65535, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
